// File: rtl/audio_pkg.sv
// audio_pkg: shared audio types, rates and the I2S transmitter state encoding
package audio_pkg;
  localparam int SAMPLE_WIDTH = 16;
  localparam int MASTER_CLK_HZ = 12_288_000;
  localparam int SAMPLE_RATE_HZ = 48_000;
  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} i2s_state_t;
endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides master_clk into BCLK and flags each BCLK falling edge one cycle later
module i2s_bclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic master_clk,
  input  logic rst,
  input  logic clr,
  output logic i2s_bclk,
  output logic fall
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_cnt;
  logic wrap;
  assign wrap = div_cnt == DW'(CLK_DIV - 1);
  // half-period counter; fall pulses in the cycle right after BCLK drops
  always_ff @(posedge master_clk) begin
    if (rst || clr) begin
      div_cnt <= '0;
      i2s_bclk <= 1'b0;
      fall <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + DW'(1);
      i2s_bclk <= i2s_bclk ^ wrap;
      fall <= wrap & i2s_bclk;
    end
  end
endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: I2S master sending a mono sample on both channels; I2S_LEFT_JUSTIFIED_EN selects left-justified
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int SAMPLE_WIDTH = audio_pkg::SAMPLE_WIDTH,
  parameter int SLOT_WIDTH = 32
) (
  input  logic master_clk,
  input  logic rst,
  input  logic tx_enable,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  output logic sample_clk_en,
  output logic i2s_bclk,
  output logic i2s_lrclk,
  output logic i2s_sdata
);
  localparam int CW = $clog2(2 * SLOT_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * SLOT_WIDTH - 1);
  i2s_state_t state, state_nxt;
  logic [CW-1:0] bit_cnt, cnt_nxt;
  logic [SAMPLE_WIDTH-1:0] hold_reg, hold_nxt;
  logic fall, wrap, start, stop, bit_on, sdata_nxt;
  int p, idx;
  i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
    .master_clk(master_clk),
    .rst(rst),
    .clr(state == IDLE),
    .i2s_bclk(i2s_bclk),
    .fall(fall)
  );
  // next state, frame position and the serial bit for the upcoming BCLK period
  always_comb begin
    wrap = bit_cnt == LAST;
    stop = fall && wrap && state == DRAIN && !tx_enable;
    start = fall && wrap && state != IDLE && !stop;
    state_nxt = state == IDLE && !tx_enable ? IDLE : tx_enable ? RUN : stop ? IDLE : DRAIN;
    cnt_nxt = wrap ? '0 : bit_cnt + CW'(1);
    hold_nxt = start ? sample_in : hold_reg;
    p = int'(cnt_nxt) % SLOT_WIDTH;
`ifdef I2S_LEFT_JUSTIFIED_EN
    bit_on = p < SAMPLE_WIDTH;
    idx = bit_on ? SAMPLE_WIDTH - 1 - p : 0;
`else
    bit_on = p >= 1 && p <= SAMPLE_WIDTH;
    idx = bit_on ? SAMPLE_WIDTH - p : 0;
`endif
    sdata_nxt = bit_on && |(hold_nxt & (SAMPLE_WIDTH'(1) << idx));
  end
  // state register
  always_ff @(posedge master_clk) begin
    state <= rst ? IDLE : state_nxt;
  end
  // sample latched only at frame start so it never changes mid-shift
  always_ff @(posedge master_clk) begin
    hold_reg <= rst ? '0 : hold_nxt;
  end
  // frame counter and registered serial outputs, advancing on BCLK fall events
  always_ff @(posedge master_clk) begin
    if (rst || state == IDLE || stop) begin
      bit_cnt <= LAST;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
      sample_clk_en <= 1'b0;
    end else begin
      sample_clk_en <= start;
      if (fall) begin
        bit_cnt <= cnt_nxt;
        i2s_lrclk <= cnt_nxt >= CW'(SLOT_WIDTH);
        i2s_sdata <= sdata_nxt;
      end
    end
  end
endmodule
